uart_rx_word_packer: RTL and testbench
======================================

# uart_rx_word_packer

Downstream consumer of the UART receive FIFO. It pops received bytes from the RX FIFO and packs them little-endian into 32-bit words. Each word is offered on a valid/ready interface to the register/bus side. Partial words are emitted on an idle timeout or an explicit flush, so the bus side moves one word per access instead of one byte.

## Interface
Parameters:
- none; the byte count per word is fixed at 4 (shared constant).

Ports:
- clk  input  1  clock
- rst_n  input  1  reset, asynchronous, active-low
- rx_fifo_empty_i  input  1  RX FIFO empty flag
- rx_fifo_data_i  input  8  RX FIFO head entry; valid whenever rx_fifo_empty_i=0
- rx_fifo_read_o  output  1  pop strobe to RX FIFO; one byte consumed per cycle asserted
- en_i  input  1  packing enable
- flush_i  input  1  single-cycle request to emit the current partial word
- timeout_i  input  16  idle cycles before a partial word is emitted; 0 disables the timeout
- word_valid_o  output  1  packed word available
- word_ready_i  input  1  consumer accepts the word
- word_data_o  output  32  packed word; first byte in [7:0]; unused lanes are 0
- word_bytes_o  output  3  number of valid bytes, 1..4; 0 when word_valid_o=0

## Operation
- States: PACK_COLLECT and PACK_HOLD. Reset state is PACK_COLLECT.
- PACK_COLLECT:
  - rx_fifo_read_o = en_i & !rx_fifo_empty_i. This is combinational.
  - On a pop, rx_fifo_data_i is written into lane byte_cnt and byte_cnt increments.
  - Next-state priority, evaluated on the post-pop count:
    1. count = 4 → HOLD.
    2. flush_i and count > 0 → HOLD.
    3. No pop, byte_cnt > 0, timeout_i != 0 and idle_cnt == timeout_i → HOLD.
    4. Otherwise stay in COLLECT.
- PACK_HOLD:
  - word_valid_o=1. word_data_o and word_bytes_o are held stable.
  - rx_fifo_read_o=0.
  - On word_ready_i: clear the data register to 0, set byte_cnt=0 and idle_cnt=0, then go to COLLECT.
- idle_cnt (16-bit):
  - Cleared on every pop and while byte_cnt = 0.
  - Increments each COLLECT cycle with no pop while en_i=1 and byte_cnt > 0.
  - Saturates at 16'hFFFF and never wraps.
- en_i=0: no pops and idle_cnt frozen. A partial word is retained. flush_i is still honoured.
- flush_i with byte_cnt = 0 and no pop in the same cycle: ignored. It is not latched.
- flush_i in PACK_HOLD: ignored.
- Changes to timeout_i take effect immediately on the compare.
- Reset mid-operation: the partial word is discarded and every output returns to its reset value on the next cycle. Bytes already popped are lost.

## Timing
- Reset values: rx_fifo_read_o=0, word_valid_o=0, word_data_o=32'h0, word_bytes_o=0.
- A pop asserted in cycle N is captured at edge N. The FIFO head and empty flag update after that same edge.
- Back-to-back pops: one per cycle.
- Full-word latency: 4th pop in cycle N → word_valid_o=1 in cycle N+1.
- Timeout latency: last pop in cycle N → idle_cnt reaches T in cycle N+1+T → word_valid_o=1 in cycle N+2+T.
- Flush latency: flush_i in cycle N → word_valid_o=1 in cycle N+1.
- Ready timing:
  - word_ready_i may be high before valid; the transfer occurs in the first cycle where both are high.
  - word_valid_o drops in the following cycle.
  - The earliest next pop is that following cycle.
- word_valid_o must never deassert without a transfer.

## Structure
- Add enum type_uart_pack_states_e {UART_PACK_COLLECT, UART_PACK_HOLD} to uart_defs.svh.
- Add constant UART_PACK_BYTES = 4 to uart_defs.svh.
- No sub-module. Single flat module: state register, lane-write data register, 3-bit byte_cnt, 16-bit idle_cnt, next-state/control always_comb.
- Instantiated beside uart_rx, wired to its rx_fifo_read_i, rx_fifo_empty_o and rx_fifo_data_o.

## Test plan
- Full word: FIFO preloaded with 0x11,0x22,0x33,0x44, ready held high → 4 consecutive pops; word_data_o=32'h44332211, word_bytes_o=4, valid for exactly 1 cycle.
- Timeout partial: timeout_i=10, bytes 0xA5,0x5A then FIFO empty → word_data_o=32'h00005AA5, word_bytes_o=2, valid in cycle last_pop+12.
- Backpressure: word_ready_i=0 for 20 cycles with 6 bytes queued → no pops during HOLD; data stable; after ready, the remaining 2 bytes are packed into the next word.
- Flush and disable:
  - flush_i with 1 byte held → word_bytes_o=1 next cycle.
  - flush_i with 0 bytes → no valid.
  - en_i=0 with a non-empty FIFO → rx_fifo_read_o stays 0.
- Simultaneous events: flush_i in the same cycle as the 3rd pop → word_bytes_o=3. timeout_i=0 with 1 byte waiting 1000 cycles → no valid.
- Reset mid-word: rst_n low after 2 pops → all outputs zero; the next 4 bytes form a fresh word starting at lane 0.

Source files
------------

// File: rtl/uart_rx_word_packer_pkg.sv
// Shared constants and state encoding for the UART RX word packer.
// Bytes are packed little-endian into one bus word.
package uart_rx_word_packer_pkg;

    localparam int unsigned UART_PACK_BYTES  = 4;
    localparam int unsigned UART_PACK_WORD_W = 8 * UART_PACK_BYTES;
    localparam int unsigned UART_PACK_CNT_W  = 3;
    localparam int unsigned UART_PACK_IDLE_W = 16;

    typedef enum logic {
        UART_PACK_COLLECT,
        UART_PACK_HOLD
    } type_uart_pack_states_e;

endpackage

// File: rtl/uart_rx_word_packer.sv
// Pops bytes from the UART RX FIFO and packs them little-endian into 32-bit words.
// Partial words leave on an idle timeout or an explicit flush.
module uart_rx_word_packer
    import uart_rx_word_packer_pkg::*;
(
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        rx_fifo_empty_i,
    input  logic [7:0]                  rx_fifo_data_i,
    output logic                        rx_fifo_read_o,
    input  logic                        en_i,
    input  logic                        flush_i,
    input  logic [UART_PACK_IDLE_W-1:0] timeout_i,
    output logic                        word_valid_o,
    input  logic                        word_ready_i,
    output logic [UART_PACK_WORD_W-1:0] word_data_o,
    output logic [UART_PACK_CNT_W-1:0]  word_bytes_o
);

    localparam logic [UART_PACK_CNT_W-1:0] FULL_CNT = UART_PACK_CNT_W'(UART_PACK_BYTES);

    type_uart_pack_states_e        state_q, state_d;
    logic [UART_PACK_WORD_W-1:0]   data_q, data_d;
    logic [UART_PACK_CNT_W-1:0]    byte_cnt_q, byte_cnt_d;
    logic [UART_PACK_IDLE_W-1:0]   idle_cnt_q, idle_cnt_d;

    logic                          pop;
    logic                          word_clear;
    logic [UART_PACK_CNT_W-1:0]    cnt_post;
    logic                          timeout_hit;
    logic [UART_PACK_BYTES-1:0]    lane_we;

    // Gated by rst_n so the FIFO is never popped while the packer is held in reset.
    assign pop      = rst_n && (state_q == UART_PACK_COLLECT) && en_i && !rx_fifo_empty_i;
    assign cnt_post = byte_cnt_q + {{(UART_PACK_CNT_W-1){1'b0}}, pop};

    assign timeout_hit = !pop && (byte_cnt_q != '0) && (timeout_i != '0)
                         && (idle_cnt_q == timeout_i);

    for (genvar gi = 0; gi < UART_PACK_BYTES; gi++) begin : g_lane
        assign lane_we[gi] = pop && (byte_cnt_q == UART_PACK_CNT_W'(gi));

        always_comb begin
            data_d[8*gi +: 8] = data_q[8*gi +: 8];
            if (word_clear) begin
                data_d[8*gi +: 8] = 8'h00;
            end else if (lane_we[gi]) begin
                data_d[8*gi +: 8] = rx_fifo_data_i;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        idle_cnt_d = idle_cnt_q;
        word_clear = 1'b0;

        case (state_q)
            UART_PACK_COLLECT: begin
                byte_cnt_d = cnt_post;

                if (pop || (byte_cnt_q == '0)) begin
                    idle_cnt_d = '0;
                end else if (en_i && (idle_cnt_q != '1)) begin
                    idle_cnt_d = idle_cnt_q + 1'b1;
                end

                // Decisions use the post-pop count so a flush alongside a pop includes that byte.
                if (cnt_post == FULL_CNT) begin
                    state_d = UART_PACK_HOLD;
                end else if (flush_i && (cnt_post != '0)) begin
                    state_d = UART_PACK_HOLD;
                end else if (timeout_hit) begin
                    state_d = UART_PACK_HOLD;
                end
            end

            UART_PACK_HOLD: begin
                if (word_ready_i) begin
                    word_clear = 1'b1;
                    byte_cnt_d = '0;
                    idle_cnt_d = '0;
                    state_d    = UART_PACK_COLLECT;
                end
            end

            default: begin
                state_d = UART_PACK_COLLECT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= UART_PACK_COLLECT;
            data_q     <= '0;
            byte_cnt_q <= '0;
            idle_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            data_q     <= data_d;
            byte_cnt_q <= byte_cnt_d;
            idle_cnt_q <= idle_cnt_d;
        end
    end

    assign rx_fifo_read_o = pop;
    assign word_valid_o   = (state_q == UART_PACK_HOLD);
    assign word_data_o    = word_valid_o ? data_q : '0;
    assign word_bytes_o   = word_valid_o ? byte_cnt_q : '0;

endmodule

// File: tb/tb_uart_rx_word_packer.sv
// Directed bench for uart_rx_word_packer: a FIFO model feeds bytes, a monitor
// scores every transferred word against a queue of hand-computed expectations.
module tb_uart_rx_word_packer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rx_fifo_empty_i;
    logic [7:0]  rx_fifo_data_i;
    logic        rx_fifo_read_o;
    logic        en_i = 1'b1;
    logic        flush_i = 1'b0;
    logic [15:0] timeout_i = 16'd0;
    logic        word_valid_o;
    logic        word_ready_i = 1'b1;
    logic [31:0] word_data_o;
    logic [2:0]  word_bytes_o;

    always #5 clk = ~clk;

    uart_rx_word_packer dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .rx_fifo_empty_i (rx_fifo_empty_i),
        .rx_fifo_data_i  (rx_fifo_data_i),
        .rx_fifo_read_o  (rx_fifo_read_o),
        .en_i            (en_i),
        .flush_i         (flush_i),
        .timeout_i       (timeout_i),
        .word_valid_o    (word_valid_o),
        .word_ready_i    (word_ready_i),
        .word_data_o     (word_data_o),
        .word_bytes_o    (word_bytes_o)
    );

    // FIFO model: head visible while non-empty, popped on the clock edge.
    logic [7:0] fifo_mem [0:255];
    logic [7:0] wr_ptr = 8'd0;
    logic [7:0] rd_ptr = 8'd0;
    int         cyc = 0;
    int         pop_cnt = 0;
    int         last_pop_cyc = 0;

    assign rx_fifo_empty_i = (wr_ptr == rd_ptr);
    assign rx_fifo_data_i  = fifo_mem[rd_ptr];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rx_fifo_read_o) begin
            rd_ptr       <= rd_ptr + 8'd1;
            pop_cnt      <= pop_cnt + 1;
            last_pop_cyc <= cyc;
        end
    end

    int tests = 0;
    int fails = 0;

    function automatic void check(input bit ok, input string name,
                                  input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    typedef struct {
        logic [31:0] data;
        logic [2:0]  bytes;
    } exp_t;

    exp_t exp_q[$];
    exp_t exp_e;

    // Monitor
    bit          prev_hold = 1'b0;
    bit          prev_valid = 1'b0;
    logic [31:0] prev_data = '0;
    logic [2:0]  prev_bytes = '0;
    int          rise_cnt = 0;
    int          rise_cyc = 0;
    int          cur_len = 0;
    int          last_len = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_hold  = 1'b0;
            prev_valid = 1'b0;
        end else begin
            if (prev_hold) begin
                check(word_valid_o === 1'b1, "valid_held", word_valid_o, 1);
                check(word_data_o === prev_data && word_bytes_o === prev_bytes, "hold_stable",
                      {29'd0, word_bytes_o, word_data_o}, {29'd0, prev_bytes, prev_data});
            end
            if (!word_valid_o && (word_data_o !== 32'h0 || word_bytes_o !== 3'd0)) begin
                check(1'b0, "idle_outputs_zero", {29'd0, word_bytes_o, word_data_o}, 0);
            end
            if (word_valid_o && !prev_valid) begin
                rise_cnt++;
                rise_cyc = cyc;
                cur_len  = 1;
            end else if (word_valid_o) begin
                cur_len++;
            end
            if (word_valid_o && word_ready_i) begin
                last_len = cur_len;
                if (exp_q.size() == 0) begin
                    check(1'b0, "unexpected_word", {29'd0, word_bytes_o, word_data_o}, 0);
                end else begin
                    exp_e = exp_q.pop_front();
                    $display("[TB] word 0x%08h bytes %0d (expected 0x%08h bytes %0d)",
                             word_data_o, word_bytes_o, exp_e.data, exp_e.bytes);
                    check(word_data_o === exp_e.data, "word_data", word_data_o, exp_e.data);
                    check(word_bytes_o === exp_e.bytes, "word_bytes", word_bytes_o, exp_e.bytes);
                end
            end
            prev_hold  = word_valid_o && !word_ready_i;
            prev_valid = word_valid_o;
            prev_data  = word_data_o;
            prev_bytes = word_bytes_o;
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic push(input logic [7:0] b);
        fifo_mem[wr_ptr] = b;
        wr_ptr = wr_ptr + 8'd1;
    endtask

    task automatic expect_word(input logic [31:0] d, input logic [2:0] b);
        exp_t e;
        e.data  = d;
        e.bytes = b;
        exp_q.push_back(e);
    endtask

    task automatic wait_drain(input string name, input int max_cyc);
        int n = 0;
        while (exp_q.size() != 0 && n < max_cyc) begin
            tick();
            n++;
        end
        check(exp_q.size() == 0, name, exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        check(rx_fifo_read_o === 1'b0, {tag, "_read"}, rx_fifo_read_o, 0);
        check(word_valid_o === 1'b0, {tag, "_valid"}, word_valid_o, 0);
        check(word_data_o === 32'h0, {tag, "_data"}, word_data_o, 0);
        check(word_bytes_o === 3'd0, {tag, "_bytes"}, word_bytes_o, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int rel_cyc;
        int fc;
        int p0;
        int r0;

        // Reset with a full word already queued: nothing may be popped.
        push(8'h11); push(8'h22); push(8'h33); push(8'h44);
        ticks(3);
        check_reset_outputs("reset");
        check(pop_cnt == 0, "reset_no_pop", pop_cnt, 0);

        // Full word, ready held high.
        expect_word(32'h44332211, 3'd4);
        rst_n   = 1'b1;
        rel_cyc = cyc;
        wait_drain("full_word_drain", 20);
        check(last_pop_cyc - rel_cyc == 3, "full_pops_consecutive", last_pop_cyc - rel_cyc, 3);
        check(rise_cyc - last_pop_cyc == 1, "full_latency", rise_cyc - last_pop_cyc, 1);
        check(last_len == 1, "full_valid_one_cycle", last_len, 1);

        // Idle timeout emits a 2-byte partial word.
        timeout_i = 16'd10;
        push(8'hA5); push(8'h5A);
        expect_word(32'h00005AA5, 3'd2);
        wait_drain("timeout_drain", 40);
        check(rise_cyc - last_pop_cyc == 12, "timeout_latency", rise_cyc - last_pop_cyc, 12);
        timeout_i = 16'd0;

        // Backpressure: six bytes queued, consumer stalls for 20 cycles.
        word_ready_i = 1'b0;
        p0 = pop_cnt;
        push(8'h01); push(8'h02); push(8'h03); push(8'h04); push(8'h05); push(8'h06);
        expect_word(32'h04030201, 3'd4);
        expect_word(32'h00000605, 3'd2);
        ticks(20);
        check(pop_cnt - p0 == 4, "hold_no_pop", pop_cnt - p0, 4);
        word_ready_i = 1'b1;
        ticks(6);
        check(pop_cnt - p0 == 6, "after_ready_pops", pop_cnt - p0, 6);
        flush_i = 1'b1;
        fc = cyc;
        tick();
        flush_i = 1'b0;
        wait_drain("backpressure_drain", 10);
        check(rise_cyc - fc == 1, "flush_latency_2b", rise_cyc - fc, 1);

        // Flush with a single byte held.
        push(8'h77);
        ticks(3);
        expect_word(32'h00000077, 3'd1);
        flush_i = 1'b1;
        fc = cyc;
        tick();
        flush_i = 1'b0;
        wait_drain("flush_1b_drain", 10);
        check(rise_cyc - fc == 1, "flush_latency_1b", rise_cyc - fc, 1);

        // Flush with nothing held is ignored.
        r0 = rise_cnt;
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        ticks(5);
        check(rise_cnt == r0, "flush_empty_ignored", rise_cnt - r0, 0);

        // Disabled: FIFO non-empty but never popped.
        en_i = 1'b0;
        p0 = pop_cnt;
        push(8'h99);
        for (int i = 0; i < 10; i++) begin
            tick();
            check(rx_fifo_read_o === 1'b0, "disabled_read", rx_fifo_read_o, 0);
        end
        check(pop_cnt == p0, "disabled_no_pop", pop_cnt - p0, 0);
        en_i = 1'b1;
        ticks(3);
        expect_word(32'h00000099, 3'd1);
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        wait_drain("enable_flush_drain", 10);

        // Flush coincident with the third pop includes that byte.
        push(8'hC1); push(8'hC2); push(8'hC3);
        expect_word(32'h00C3C2C1, 3'd3);
        ticks(2);
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        wait_drain("flush_3rd_pop_drain", 10);

        // Timeout disabled: a lone byte waits indefinitely.
        r0 = rise_cnt;
        push(8'hE1);
        ticks(1000);
        check(rise_cnt == r0, "timeout_disabled", rise_cnt - r0, 0);

        // Reset after two bytes held: word discarded, fresh word starts at lane 0.
        push(8'hE2);
        ticks(3);
        rst_n = 1'b0;
        push(8'hF0);
        tick();
        check_reset_outputs("midreset");
        tick();
        rst_n = 1'b1;
        push(8'h02); push(8'h03); push(8'h04);
        expect_word(32'h040302F0, 3'd4);
        wait_drain("post_reset_drain", 20);

        ticks(3);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
